// File: rtl/seq_encoder8to3.sv
// Purpose: captures a multi-hot request vector and drains it as binary indices, one per handshake.
// Latency: first index one cycle after accept; done pulses one cycle after the last beat.
// Backpressure: out_ready=0 or en=0 holds the current index; in_ready is low while draining.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   en                  block enable; gates acceptance and emission
//   in_valid, in        request vector (any number of bits set, including none)
//   in_ready            a vector can be captured this cycle (IDLE and en)
//   out_valid, out_ready, out_idx, out_last
//                       index stream in priority order; out_last marks the final set bit
//   done                one-cycle pulse once a vector has been fully drained
module seq_encoder8to3 #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic             state;
  logic [WIDTH-1:0] pend;
  logic [IDX_W-1:0] enc_idx;
  logic             one_left;
  logic             out_hs;

  // Priority encoder over the pending bits. The scan runs toward the
  // preferred end, so the last hit in the loop is the winning index.
  always_comb begin
    enc_idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pend[i]) enc_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pend[i]) enc_idx = IDX_W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_left  = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  assign in_ready  = en && (state == IDLE);
  assign out_valid = en && (state == BUSY);
  // Index and last flag stay visible while en=0 so emission resumes on the same beat.
  assign out_idx   = (state == BUSY) ? enc_idx : '0;
  assign out_last  = (state == BUSY) && one_left;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && in_valid) begin
            if (in != '0) begin
              pend  <= in;
              state <= BUSY;
            end else begin
              // An empty vector has nothing to drain; report completion directly.
              done <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (out_hs) begin
            pend <= pend & ~(WIDTH'(1) << enc_idx);
            if (one_left) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          pend  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_encoder8to3.sv
module tb_seq_encoder8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_done;
  logic [2:0] a_out_idx;
  logic       b_in_ready, b_out_valid, b_out_last, b_done;
  logic [2:0] b_out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_encoder8to3 #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_last(a_out_last), .done(a_done)
  );

  seq_encoder8to3 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the LSB-first instance's output beat.
  task automatic beat_a(input string tag, input logic v, input logic [2:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".idx"},   32'(a_out_idx),   32'(idx));
    chk({tag, ".last"},  32'(a_out_last),  32'(last));
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in = 8'h00; out_ready = 1'b1;
    #1;
    // Reset state
    beat_a("rst", 1'b0, 3'd0, 1'b0);
    chk("rst.done", 32'(a_done), 32'd0);
    chk("rst.in_ready_en0", 32'(a_in_ready), 32'd0);
    step();
    rst_n = 1'b1; en = 1'b1;
    #1;
    chk("rst.in_ready_en1", 32'(a_in_ready), 32'd1);
    step();

    // Test 1: A4 with out_ready=1 -> 2,5,7 then done
    in = 8'hA4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_a("t1.b0", 1'b1, 3'd2, 1'b0);
    chk("t1.in_ready_busy", 32'(a_in_ready), 32'd0);
    step(); beat_a("t1.b1", 1'b1, 3'd5, 1'b0);
    step(); beat_a("t1.b2", 1'b1, 3'd7, 1'b1);
    step();
    chk("t1.done", 32'(a_done), 32'd1);
    beat_a("t1.idle", 1'b0, 3'd0, 1'b0);
    chk("t1.in_ready_done", 32'(a_in_ready), 32'd1);
    step();
    chk("t1.done_drop", 32'(a_done), 32'd0);

    // Test 2: first beat stalled for 3 cycles
    in = 8'hA4; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    beat_a("t2.hold0", 1'b1, 3'd2, 1'b0);
    step(); beat_a("t2.hold1", 1'b1, 3'd2, 1'b0);
    step(); beat_a("t2.hold2", 1'b1, 3'd2, 1'b0);
    chk("t2.no_done", 32'(a_done), 32'd0);
    out_ready = 1'b1;
    step(); beat_a("t2.b1", 1'b1, 3'd5, 1'b0);
    step(); beat_a("t2.b2", 1'b1, 3'd7, 1'b1);
    step(); chk("t2.done", 32'(a_done), 32'd1);
    step();

    // Test 3: empty vector -> no beats, done one cycle after accept
    in = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t3.done", 32'(a_done), 32'd1);
    chk("t3.valid", 32'(a_out_valid), 32'd0);
    chk("t3.in_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("t3.done_drop", 32'(a_done), 32'd0);
    chk("t3.valid2", 32'(a_out_valid), 32'd0);

    // Test 4: MSB-first instance drains FF as 7..0
    in = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4.b%0d.valid", i), 32'(b_out_valid), 32'd1);
      chk($sformatf("t4.b%0d.idx", i), 32'(b_out_idx), 32'(7 - i));
      chk($sformatf("t4.b%0d.last", i), 32'(b_out_last), 32'(i == 7));
      chk($sformatf("t4.b%0d.in_ready", i), 32'(b_in_ready), 32'd0);
      step();
    end
    chk("t4.done", 32'(b_done), 32'd1);
    chk("t4.valid_end", 32'(b_out_valid), 32'd0);
    step();

    // Test 5: en=0 for 2 cycles after beat 5; in_valid during BUSY ignored
    in = 8'hA4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_a("t5.b0", 1'b1, 3'd2, 1'b0);
    step(); beat_a("t5.b1", 1'b1, 3'd5, 1'b0);
    step();
    en = 1'b0; in = 8'h01; in_valid = 1'b1;
    #1;
    beat_a("t5.off0", 1'b0, 3'd7, 1'b1);
    step(); beat_a("t5.off1", 1'b0, 3'd7, 1'b1);
    chk("t5.in_ready_off", 32'(a_in_ready), 32'd0);
    step(); beat_a("t5.off2", 1'b0, 3'd7, 1'b1);
    en = 1'b1;
    #1;
    beat_a("t5.resume", 1'b1, 3'd7, 1'b1);
    chk("t5.in_ready_busy", 32'(a_in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("t5.done", 32'(a_done), 32'd1);
    beat_a("t5.idle", 1'b0, 3'd0, 1'b0);
    step();

    // Test 6: reset mid-drain, then single-bit vector
    in = 8'hA4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_a("t6.b0", 1'b1, 3'd2, 1'b0);
    step(); beat_a("t6.b1", 1'b1, 3'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    beat_a("t6.rst", 1'b0, 3'd0, 1'b0);
    chk("t6.rst_done", 32'(a_done), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6.in_ready", 32'(a_in_ready), 32'd1);
    in = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat_a("t6.single", 1'b1, 3'd4, 1'b1);
    step();
    chk("t6.done", 32'(a_done), 32'd1);
    beat_a("t6.idle", 1'b0, 3'd0, 1'b0);
    step();
    chk("t6.done_drop", 32'(a_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
